sync_fifo_flags: RTL and testbench



---
 rtl/sync_fifo_flags.sv | 132 +++++++++++++
 tb/tb_sync_fifo_flags.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// ---------------------------------------------------------------------------
// sync_fifo_flags
//
// Single-clock first-word-fall-through FIFO that sits between repacketizer
// pipeline stages sharing one clock. It adds an occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow error
// flags and a synchronous flush.
//
// Handshake: a write is taken on a rising edge when enable_in=1 and
// full_in=0. A read is taken on a rising edge when enable_out=1 and
// empty_out=0. While empty_out=0, data_out already shows the head entry,
// so the consumer samples data_out in the same cycle that it raises
// enable_out. A request made against the wrong flag is dropped and sets
// the matching sticky error flag. flush=1 overrides both requests.
//
// Ports:
//   clk          single clock; all state changes on its rising edge
//   reset        asynchronous, active-high clear of pointers, count, flags
//   flush        synchronous clear of contents and error flags
//   data_in      write data
//   enable_in    write request
//   full_in      FIFO holds DEPTH entries
//   data_out     head entry; reads as 0 while empty_out=1
//   enable_out   read request; pops the head entry
//   empty_out    FIFO holds 0 entries
//   count        current occupancy, 0..DEPTH
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_POWER = 4,
    parameter int AF_LEVEL   = (1 << FIFO_POWER) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  enable_in,
    output logic                  full_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  enable_out,
    output logic                  empty_out,
    output logic [FIFO_POWER:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << FIFO_POWER;

    localparam logic [FIFO_POWER:0]   CNT_DEPTH = (FIFO_POWER + 1)'(DEPTH);
    localparam logic [FIFO_POWER:0]   CNT_AF    = (FIFO_POWER + 1)'(AF_LEVEL);
    localparam logic [FIFO_POWER:0]   CNT_AE    = (FIFO_POWER + 1)'(AE_LEVEL);
    localparam logic [FIFO_POWER:0]   CNT_ONE   = (FIFO_POWER + 1)'(1);
    localparam logic [FIFO_POWER-1:0] PTR_ONE   = FIFO_POWER'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_POWER-1:0] wr_ptr;
    logic [FIFO_POWER-1:0] rd_ptr;
    logic [FIFO_POWER:0]   count_next;
    logic                  wr_acc;
    logic                  rd_acc;

    // All flags decode from the registered count only, so no request input
    // ever reaches a flag combinationally.
    assign full_in      = (count == CNT_DEPTH);
    assign empty_out    = (count == '0);
    assign almost_full  = (count >= CNT_AF);
    assign almost_empty = (count <= CNT_AE);

    // Acceptance uses the pre-edge flags: when full, a simultaneous read
    // still cannot make room for the write in the same cycle (and vice
    // versa when empty).
    assign wr_acc = enable_in  & ~full_in   & ~flush;
    assign rd_acc = enable_out & ~empty_out & ~flush;

    // Head is forced to zero while empty so stale array contents never leak
    // out, including right after an asynchronous reset.
    assign data_out = empty_out ? '0 : mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // Storage array is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
            if (enable_in & full_in) begin
                overflow <= 1'b1;
            end
            if (enable_out & empty_out) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_flags
//
// Bench for sync_fifo_flags at DATA_WIDTH=8, FIFO_POWER=2, AF_LEVEL=3,
// AE_LEVEL=1. Stimulus pushes every word the FIFO should accept into
// exp_q; an independent monitor pops and compares whenever the DUT shows a
// valid head that is being read. Occupancy and flags are checked against
// a small occupancy model after every clock.
// ---------------------------------------------------------------------------
module tb_sync_fifo_flags;

    localparam int DW    = 8;
    localparam int FP    = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          enable_in = 1'b0;
    logic          full_in;
    logic [DW-1:0] data_out;
    logic          enable_out = 1'b0;
    logic          empty_out;
    logic [FP:0]   count;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];
    int            mc = 0;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    logic [DW-1:0] pat = 8'h00;

    sync_fifo_flags #(
        .DATA_WIDTH(DW),
        .FIFO_POWER(FP),
        .AF_LEVEL  (AF),
        .AE_LEVEL  (AE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .data_in     (data_in),
        .enable_in   (enable_in),
        .full_in     (full_in),
        .data_out    (data_out),
        .enable_out  (enable_out),
        .empty_out   (empty_out),
        .count       (count),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"},        32'(count),        32'(mc));
        chk({tag, ".full_in"},      32'(full_in),      32'(mc == DEPTH));
        chk({tag, ".empty_out"},    32'(empty_out),    32'(mc == 0));
        chk({tag, ".almost_full"},  32'(almost_full),  32'(mc >= AF));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(mc <= AE));
        chk({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
        chk({tag, ".underflow"},    32'(underflow),    32'(m_unf));
        if (mc == 0) begin
            chk({tag, ".data_out_zero"}, 32'(data_out), 32'h0);
        end else if (exp_q.size() > 0) begin
            chk({tag, ".head"}, 32'(data_out), 32'(exp_q[0]));
        end
    endtask

    // ---------------- monitor ----------------
    // Samples on the falling edge, where inputs are stable; a read that will
    // be taken at the next rising edge must present the expected head.
    always @(negedge clk) begin
        if (!reset && enable_out && !flush && !empty_out) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL read_unexpected: got %0h expected no output", data_out);
            end else begin
                chk("read_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input bit we, input bit re, input logic [DW-1:0] din,
                        input bit fl, input string tag);
        bit wa;
        bit ra;
        enable_in  = we;
        enable_out = re;
        data_in    = din;
        flush      = fl;
        wa = we && (mc != DEPTH) && !fl;
        ra = re && (mc != 0) && !fl;
        if (wa) exp_q.push_back(din);
        if (!fl) begin
            if (we && mc == DEPTH) m_ovf = 1'b1;
            if (re && mc == 0)     m_unf = 1'b1;
        end
        @(posedge clk);
        #1;
        if (fl) begin
            mc    = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
            exp_q.delete();
        end else begin
            mc = mc + int'(wa) - int'(ra);
        end
        enable_in  = 1'b0;
        enable_out = 1'b0;
        flush      = 1'b0;
        check_state(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] fill_vec [4];
        fill_vec[0] = 8'h11;
        fill_vec[1] = 8'h22;
        fill_vec[2] = 8'h33;
        fill_vec[3] = 8'h44;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_state("post_reset");

        // Fill and drain in order
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, fill_vec[i], 1'b0, "fill");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "drain");

        // Overflow: 0x55 must be dropped, overflow sticky until flush
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, fill_vec[i], 1'b0, "refill");
        step(1'b1, 1'b0, 8'h55, 1'b0, "overflow");
        step(1'b0, 1'b0, 8'h00, 1'b0, "overflow_hold");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "drain_ovf");
        step(1'b0, 1'b0, 8'h00, 1'b1, "flush_ovf");

        // Simultaneous read+write while empty
        step(1'b1, 1'b1, 8'hA5, 1'b0, "empty_rw");
        step(1'b0, 1'b1, 8'h00, 1'b0, "read_a5");
        step(1'b0, 1'b0, 8'h00, 1'b1, "flush_unf");

        // Simultaneous read+write while full
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, fill_vec[i], 1'b0, "fill_rw");
        step(1'b1, 1'b1, 8'h66, 1'b0, "full_rw");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "drain_rw");

        // Flush with concurrent requests sets nothing
        step(1'b1, 1'b0, 8'h01, 1'b0, "pre_flush");
        step(1'b1, 1'b1, 8'h02, 1'b1, "flush_req");

        // Random streaming with incrementing data across many wraps
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pat, 1'b0, "stream");
            pat = pat + 8'h01;
        end
        step(1'b0, 1'b0, 8'h00, 1'b1, "flush_stream");

        // Asynchronous reset between edges at count=3
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, fill_vec[i], 1'b0, "pre_areset");
        #2;
        reset = 1'b1;
        #1;
        mc    = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        exp_q.delete();
        check_state("areset_mid");
        @(posedge clk);
        #1;
        check_state("areset_held");
        reset = 1'b0;
        step(1'b1, 1'b0, 8'h77, 1'b0, "after_reset");
        step(1'b0, 1'b1, 8'h00, 1'b0, "read_77");

        // Drain anything left, bounded
        for (int g = 0; g < 2 * DEPTH && mc > 0; g++) step(1'b0, 1'b1, 8'h00, 1'b0, "final_drain");
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
